// File: rtl/operand_stager_pkg.sv
// Shared definitions for the operand stager: FSM encoding, counter sizing and
// flat-bus lane addressing.
package operand_stager_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int cnt_w(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  // Bit offset of a lane inside a flat N*w bus.
  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/operand_bank.sv
// Single-port word bank for one lane; data_out is registered and holds its
// value whenever rd_en is low.
module operand_bank
  import operand_stager_pkg::*;
#(
  parameter int D_W = 8,
  parameter int K   = 8,
  parameter int AW  = cnt_w(K)
) (
  input  logic           clk,
  input  logic           wr_en,
  input  logic           rd_en,
  input  logic [AW-1:0]  addr,
  input  logic [D_W-1:0] data_in,
  output logic [D_W-1:0] data_out
);

  logic [D_W-1:0] mem [K];

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= data_in;
    if (rd_en) data_out <= mem[addr];
  end

endmodule

// File: rtl/operand_stager.sv
// Serial X/Y operand loader into per-lane banks, and a diagonally skewed
// replay of those banks toward the systolic array edges.
module operand_stager
  import operand_stager_pkg::*;
#(
  parameter int D_W = 8,
  parameter int N   = 2,
  parameter int K   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_x,
  input  logic             ser_y,
  input  logic             ser_valid,
  input  logic             load_start,
  input  logic             xfer_start,
  output logic             busy,
  output logic             loaded,
  output logic             load_done,
  output logic             xfer_done,
  output logic             err,
  output logic [N*D_W-1:0] out_x_flat,
  output logic [N*D_W-1:0] out_y_flat,
  output logic [N-1:0]     out_valid
);

  localparam int NK = N * K;
  localparam int BW = cnt_w(D_W);
  localparam int WW = cnt_w(K);
  localparam int LW = cnt_w(N);
  localparam int SW = cnt_w(N + K);
  localparam int CW = cnt_w(NK + 1);

  state_t state_reg, state_next;

  logic [BW-1:0]  bit_cnt_reg;
  logic [WW-1:0]  word_cnt_reg;
  logic [LW-1:0]  lane_cnt_reg;
  logic [CW-1:0]  cap_cnt_reg;
  logic [SW-1:0]  step_reg;
  logic [D_W-1:0] shift_x_reg, shift_y_reg;
  logic [D_W-1:0] word_x_reg, word_y_reg;
  logic           wr_pend_reg;
  logic           loaded_reg;
  logic           load_done_reg;
  logic           xfer_done_reg;
  logic           err_reg;
  logic [N-1:0]   valid_reg;

  logic           load_go, xfer_go, take_bit, word_full, last_write, xfer_last, cmd_err;
  logic [D_W-1:0] x_in, y_in, shifted_x, shifted_y;
  logic           lead_en;
  logic [WW-1:0]  lead_addr;
  logic [N-1:0]   lane_en;
  logic [WW-1:0]  lane_addr [N];

  assign load_go    = (state_reg == ST_IDLE) && load_start;
  assign xfer_go    = (state_reg == ST_IDLE) && xfer_start && !load_start && loaded_reg;
  // Once every word has been captured, further serial bits are dropped.
  assign take_bit   = (state_reg == ST_LOAD) && ser_valid && (cap_cnt_reg != CW'(NK));
  assign word_full  = take_bit && (bit_cnt_reg == BW'(D_W - 1));
  assign last_write = wr_pend_reg && (lane_cnt_reg == LW'(N - 1)) && (word_cnt_reg == WW'(K - 1));
  assign xfer_last  = (state_reg == ST_XFER) && (step_reg == SW'(N + K - 1));
  assign cmd_err    = (state_reg == ST_IDLE) ? (xfer_start && (load_start || !loaded_reg))
                                             : (load_start || xfer_start);

  always_comb begin
    x_in = '0;
    y_in = '0;
    x_in[D_W-1] = ser_x;
    y_in[D_W-1] = ser_y;
    shifted_x = (shift_x_reg >> 1) | x_in;
    shifted_y = (shift_y_reg >> 1) | y_in;
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (load_start)   state_next = ST_LOAD;
        else if (xfer_go) state_next = ST_XFER;
      end
      ST_LOAD: if (last_write) state_next = ST_IDLE;
      ST_XFER: if (xfer_last)  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_reg != ST_IDLE);
    lead_en   = (state_reg == ST_XFER) && (step_reg < SW'(K));
    lead_addr = WW'(step_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_reg  <= '0;
      word_cnt_reg <= '0;
      lane_cnt_reg <= '0;
      cap_cnt_reg  <= '0;
      shift_x_reg  <= '0;
      shift_y_reg  <= '0;
      word_x_reg   <= '0;
      word_y_reg   <= '0;
      wr_pend_reg  <= 1'b0;
    end else if (load_go) begin
      bit_cnt_reg  <= '0;
      word_cnt_reg <= '0;
      lane_cnt_reg <= '0;
      cap_cnt_reg  <= '0;
      wr_pend_reg  <= 1'b0;
    end else begin
      if (take_bit) begin
        shift_x_reg <= shifted_x;
        shift_y_reg <= shifted_y;
        bit_cnt_reg <= word_full ? '0 : bit_cnt_reg + 1'b1;
      end
      // Completed words are parked so the next word can start shifting at once.
      if (word_full) begin
        word_x_reg  <= shifted_x;
        word_y_reg  <= shifted_y;
        cap_cnt_reg <= cap_cnt_reg + 1'b1;
      end
      wr_pend_reg <= word_full;
      if (wr_pend_reg) begin
        if (word_cnt_reg == WW'(K - 1)) begin
          word_cnt_reg <= '0;
          lane_cnt_reg <= (lane_cnt_reg == LW'(N - 1)) ? '0 : lane_cnt_reg + 1'b1;
        end else begin
          word_cnt_reg <= word_cnt_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loaded_reg    <= 1'b0;
      load_done_reg <= 1'b0;
      xfer_done_reg <= 1'b0;
      err_reg       <= 1'b0;
      step_reg      <= '0;
      valid_reg     <= '0;
    end else begin
      if (load_go)         loaded_reg <= 1'b0;
      else if (last_write) loaded_reg <= 1'b1;
      load_done_reg <= last_write;
      xfer_done_reg <= xfer_last;
      err_reg       <= cmd_err;
      step_reg      <= ((state_reg == ST_XFER) && !xfer_last) ? step_reg + 1'b1 : '0;
      valid_reg     <= lane_en;
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic           bank_wr;
      logic [WW-1:0]  bank_addr;
      logic [D_W-1:0] rd_x, rd_y;

      // Lane 0 is driven by the step counter; every later lane replays the
      // previous lane's read request one cycle late.
      if (gi == 0) begin : g_lead
        assign lane_en[gi]   = lead_en;
        assign lane_addr[gi] = lead_addr;
      end else begin : g_skew
        logic          en_reg;
        logic [WW-1:0] addr_reg;
        always_ff @(posedge clk) begin
          if (rst) begin
            en_reg   <= 1'b0;
            addr_reg <= '0;
          end else begin
            en_reg   <= lane_en[gi-1];
            addr_reg <= lane_addr[gi-1];
          end
        end
        assign lane_en[gi]   = en_reg;
        assign lane_addr[gi] = addr_reg;
      end

      assign bank_wr   = wr_pend_reg && (lane_cnt_reg == LW'(gi));
      assign bank_addr = bank_wr ? word_cnt_reg : lane_addr[gi];

      operand_bank #(.D_W(D_W), .K(K), .AW(WW)) u_bank_x (
        .clk      (clk),
        .wr_en    (bank_wr),
        .rd_en    (lane_en[gi]),
        .addr     (bank_addr),
        .data_in  (word_x_reg),
        .data_out (rd_x)
      );

      operand_bank #(.D_W(D_W), .K(K), .AW(WW)) u_bank_y (
        .clk      (clk),
        .wr_en    (bank_wr),
        .rd_en    (lane_en[gi]),
        .addr     (bank_addr),
        .data_in  (word_y_reg),
        .data_out (rd_y)
      );

      assign out_x_flat[lane_lsb(gi, D_W) +: D_W] = valid_reg[gi] ? rd_x : '0;
      assign out_y_flat[lane_lsb(gi, D_W) +: D_W] = valid_reg[gi] ? rd_y : '0;
    end
  endgenerate

  assign loaded    = loaded_reg;
  assign load_done = load_done_reg;
  assign xfer_done = xfer_done_reg;
  assign err       = err_reg;
  assign out_valid = valid_reg;

endmodule
